// File: rtl/ps2_direction_decoder.sv
// Turns the PS/2 scan-code byte stream into held 2-bit direction commands for
// two players plus a start strobe, handling E0/F0 prefixes and typematic repeats.
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit ALLOW_REVERSE  = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    output logic [1:0] dir_p1,
    output logic [1:0] dir_p2,
    output logic       dir_p1_changed,
    output logic       dir_p2_changed,
    output logic       go_pulse,
    output logic [7:0] last_make
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         dir_p1_q, dir_p1_d;
    logic [1:0]         dir_p2_q, dir_p2_d;
    logic               p1_chg_q, p1_chg_d;
    logic               p2_chg_q, p2_chg_d;
    logic               go_q, go_d;
    logic [7:0]         last_make_q, last_make_d;

    logic       make_valid;
    logic       make_ext;
    logic       p1_hit, p2_hit;
    logic [1:0] p1_cand, p2_cand;

    // A candidate is taken only if it changes the direction and, unless
    // reversals are allowed, is not the opposite of the current one.
    function automatic logic accept(input logic [1:0] cand, input logic [1:0] cur);
        logic opposite;
        opposite = (cand[1] == cur[1]) && (cand[0] != cur[0]);
        return (cand != cur) && (ALLOW_REVERSE || !opposite);
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        make_valid = 1'b0;
        make_ext   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (code_valid) begin
                    if (code_byte == 8'hE0)      state_d = S_EXT;
                    else if (code_byte == 8'hF0) state_d = S_BRK;
                    else                         make_valid = 1'b1;
                end
            end
            S_EXT: begin
                if (code_valid) begin
                    if (code_byte == 8'hF0)      state_d = S_EXT_BRK;
                    else if (code_byte != 8'hE0) begin
                        make_valid = 1'b1;
                        make_ext   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                if (code_valid) state_d = S_IDLE;
            end
        endcase

        // Prefix states abandon a stalled sequence; a byte restarts the wait.
        if (state_q != S_IDLE && !code_valid) begin
            if (timer_q == TIMER_MAX) state_d = S_IDLE;
            else                      timer_d = timer_q + TIMER_W'(1);
        end

        p1_hit  = 1'b0;
        p1_cand = DIR_UP;
        case (code_byte)
            8'h75: begin p1_hit = 1'b1; p1_cand = DIR_UP;    end
            8'h74: begin p1_hit = 1'b1; p1_cand = DIR_RIGHT; end
            8'h72: begin p1_hit = 1'b1; p1_cand = DIR_DOWN;  end
            8'h6B: begin p1_hit = 1'b1; p1_cand = DIR_LEFT;  end
            default: ;
        endcase

        p2_hit  = 1'b0;
        p2_cand = DIR_UP;
        case (code_byte)
            8'h1D: begin p2_hit = 1'b1; p2_cand = DIR_UP;    end
            8'h23: begin p2_hit = 1'b1; p2_cand = DIR_RIGHT; end
            8'h1B: begin p2_hit = 1'b1; p2_cand = DIR_DOWN;  end
            8'h1C: begin p2_hit = 1'b1; p2_cand = DIR_LEFT;  end
            default: ;
        endcase

        dir_p1_d    = dir_p1_q;
        dir_p2_d    = dir_p2_q;
        p1_chg_d    = 1'b0;
        p2_chg_d    = 1'b0;
        go_d        = 1'b0;
        last_make_d = last_make_q;

        if (make_valid) begin
            last_make_d = code_byte;
            if (make_ext && p1_hit && accept(p1_cand, dir_p1_q)) begin
                dir_p1_d = p1_cand;
                p1_chg_d = 1'b1;
            end
            if (!make_ext && p2_hit && accept(p2_cand, dir_p2_q)) begin
                dir_p2_d = p2_cand;
                p2_chg_d = 1'b1;
            end
            if (!make_ext && code_byte == 8'h29) go_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            dir_p1_q    <= DIR_UP;
            dir_p2_q    <= DIR_UP;
            p1_chg_q    <= 1'b0;
            p2_chg_q    <= 1'b0;
            go_q        <= 1'b0;
            last_make_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_p1_q    <= dir_p1_d;
            dir_p2_q    <= dir_p2_d;
            p1_chg_q    <= p1_chg_d;
            p2_chg_q    <= p2_chg_d;
            go_q        <= go_d;
            last_make_q <= last_make_d;
        end
    end

    assign dir_p1         = dir_p1_q;
    assign dir_p2         = dir_p2_q;
    assign dir_p1_changed = p1_chg_q;
    assign dir_p2_changed = p2_chg_q;
    assign go_pulse       = go_q;
    assign last_make      = last_make_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: one instance rejecting reversals
// and one accepting them, both with a 16-cycle prefix timeout.
module tb_ps2_direction_decoder;

    logic       CLOCK_50;
    logic       resetn;
    logic       code_valid;
    logic [7:0] code_byte;

    logic [1:0] dir_p1, dir_p2;
    logic       dir_p1_changed, dir_p2_changed, go_pulse;
    logic [7:0] last_make;

    logic [1:0] r_dir_p1, r_dir_p2;
    logic       r_dir_p1_changed, r_dir_p2_changed, r_go_pulse;
    logic [7:0] r_last_make;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_direction_decoder #(.TIMEOUT_CYCLES(16), .ALLOW_REVERSE(1'b0)) dut (
        .CLOCK_50       (CLOCK_50),
        .resetn         (resetn),
        .code_valid     (code_valid),
        .code_byte      (code_byte),
        .dir_p1         (dir_p1),
        .dir_p2         (dir_p2),
        .dir_p1_changed (dir_p1_changed),
        .dir_p2_changed (dir_p2_changed),
        .go_pulse       (go_pulse),
        .last_make      (last_make)
    );

    ps2_direction_decoder #(.TIMEOUT_CYCLES(16), .ALLOW_REVERSE(1'b1)) dut_rev (
        .CLOCK_50       (CLOCK_50),
        .resetn         (resetn),
        .code_valid     (code_valid),
        .code_byte      (code_byte),
        .dir_p1         (r_dir_p1),
        .dir_p2         (r_dir_p2),
        .dir_p1_changed (r_dir_p1_changed),
        .dir_p2_changed (r_dir_p2_changed),
        .go_pulse       (r_go_pulse),
        .last_make      (r_last_make)
    );

    // Clock and reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, mid-cycle after the active edge.
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        code_valid = 1'b1;
        code_byte  = b;
        @(negedge CLOCK_50);
        code_valid = 1'b0;
        code_byte  = $urandom_range(0, 255);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    task automatic check_strobes(input string tag, input logic p1, input logic p2, input logic go);
        check({tag, "_p1chg"}, {7'd0, dir_p1_changed}, {7'd0, p1});
        check({tag, "_p2chg"}, {7'd0, dir_p2_changed}, {7'd0, p2});
        check({tag, "_go"},    {7'd0, go_pulse},       {7'd0, go});
    endtask

    initial begin
        resetn     = 1'b0;
        code_valid = 1'b0;
        code_byte  = 8'h00;
        idle(3);
        check("rst_p1", {6'd0, dir_p1}, 8'h01);
        check("rst_p2", {6'd0, dir_p2}, 8'h01);
        check_strobes("rst", 1'b0, 1'b0, 1'b0);
        check("rst_last", last_make, 8'h00);
        resetn = 1'b1;

        // Test 1: extended right for player 1
        send(8'hE0);
        check("t1_pre_p1", {6'd0, dir_p1}, 8'h01);
        send(8'h74);
        check("t1_p1", {6'd0, dir_p1}, 8'h03);
        check_strobes("t1", 1'b1, 1'b0, 1'b0);
        check("t1_last", last_make, 8'h74);
        check("t1_p2", {6'd0, dir_p2}, 8'h01);
        idle(1);
        check_strobes("t1_after", 1'b0, 1'b0, 1'b0);

        // Test 2: reversal right -> left
        send(8'hE0);
        send(8'h6B);
        check("t2_p1", {6'd0, dir_p1}, 8'h03);
        check_strobes("t2", 1'b0, 1'b0, 1'b0);
        check("t2_last", last_make, 8'h6B);
        check("t2_rev_p1", {6'd0, r_dir_p1}, 8'h02);
        check("t2_rev_chg", {7'd0, r_dir_p1_changed}, 8'h01);
        check("t2_rev_last", r_last_make, 8'h6B);
        // Non-opposite turn is accepted by both
        send(8'hE0);
        send(8'h72);
        check("t2_down_p1", {6'd0, dir_p1}, 8'h00);
        check("t2_down_chg", {7'd0, dir_p1_changed}, 8'h01);

        // Test 3: player 2 make/break/repeat
        do_reset();
        send(8'h1C);
        check("t3_p2", {6'd0, dir_p2}, 8'h02);
        check_strobes("t3", 1'b0, 1'b1, 1'b0);
        idle(1);
        check("t3_chg_drop", {7'd0, dir_p2_changed}, 8'h00);
        send(8'hF0);
        check("t3_brk_f0", {7'd0, dir_p2_changed}, 8'h00);
        send(8'h1C);
        check("t3_brk_p2", {6'd0, dir_p2}, 8'h02);
        check("t3_brk_chg", {7'd0, dir_p2_changed}, 8'h00);
        check("t3_brk_last", last_make, 8'h1C);
        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            check($sformatf("t3_rep%0d", i), {7'd0, dir_p2_changed}, 8'h00);
            check($sformatf("t3_rep%0d_p2", i), {6'd0, dir_p2}, 8'h02);
        end
        send(8'h1B);
        check("t3_down_p2", {6'd0, dir_p2}, 8'h00);
        check("t3_down_chg", {7'd0, dir_p2_changed}, 8'h01);
        send(8'hE0);
        send(8'h23);
        check("t3_ext23_p2", {6'd0, dir_p2}, 8'h00);
        check("t3_ext23_chg", {7'd0, dir_p2_changed}, 8'h00);
        check("t3_ext23_last", last_make, 8'h23);

        // Test 4: keypad code, extended break, start key
        do_reset();
        send(8'h74);
        check("t4_kp_p1", {6'd0, dir_p1}, 8'h01);
        check_strobes("t4_kp", 1'b0, 1'b0, 1'b0);
        check("t4_kp_last", last_make, 8'h74);
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        check("t4_xbrk_p1", {6'd0, dir_p1}, 8'h01);
        check("t4_xbrk_chg", {7'd0, dir_p1_changed}, 8'h00);
        check("t4_xbrk_last", last_make, 8'h74);
        send(8'h29);
        check_strobes("t4_go", 1'b0, 1'b0, 1'b1);
        check("t4_go_last", last_make, 8'h29);
        idle(1);
        check("t4_go_drop", {7'd0, go_pulse}, 8'h00);
        send(8'hE0);
        send(8'h29);
        check("t4_extgo", {7'd0, go_pulse}, 8'h00);

        // Test 5: prefix timeout at 16 idle edges, none at 15
        do_reset();
        send(8'hE0);
        idle(15);
        send(8'h74);
        check("t5_to_p1", {6'd0, dir_p1}, 8'h01);
        check("t5_to_chg", {7'd0, dir_p1_changed}, 8'h00);
        check("t5_to_last", last_make, 8'h74);
        send(8'hE0);
        idle(14);
        send(8'h74);
        check("t5_edge_p1", {6'd0, dir_p1}, 8'h03);
        check("t5_edge_chg", {7'd0, dir_p1_changed}, 8'h01);
        send(8'hF0);
        idle(15);
        send(8'h1D);
        check("t5_brkto_last", last_make, 8'h1D);

        // Test 6: reset in the middle of a prefix
        do_reset();
        send(8'hE0);
        send(8'h74);
        check("t6_pre_p1", {6'd0, dir_p1}, 8'h03);
        send(8'hE0);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("t6_rst_p1", {6'd0, dir_p1}, 8'h01);
        check("t6_rst_p2", {6'd0, dir_p2}, 8'h01);
        check_strobes("t6_rst", 1'b0, 1'b0, 1'b0);
        check("t6_rst_last", last_make, 8'h00);
        resetn = 1'b1;
        send(8'h75);
        check("t6_p1", {6'd0, dir_p1}, 8'h01);
        check("t6_chg", {7'd0, dir_p1_changed}, 8'h00);
        check("t6_last", last_make, 8'h75);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
